// File: rtl/hash_round_engine.sv
// hash_round_engine
//   SHA-256 compression round engine. A block is started from a chaining
//   value, then consumes externally supplied W/K schedule beats, applying
//   ROUNDS_PER_CYCLE chained rounds per accepted beat. After NUM_ROUNDS
//   rounds the digest is registered (optionally with feed-forward of the
//   chaining value) and a one-cycle done pulse is issued.
//
// Ports
//   clock        : single clock, rising-edge active
//   reset        : asynchronous active-low reset
//   start        : begin a block (honoured in IDLE only)
//   abort        : cancel the block in progress (priority over everything)
//   feed_forward : sampled with start; 1 = add prev_hash to the final state
//   prev_hash    : chaining value, word a in [31:0] ... word h in [255:224]
//   w_valid      : schedule beat valid
//   w_data       : W words, lowest-index round in [31:0]
//   k_data       : K constants, packed like w_data
//   w_ready      : engine accepts a beat this cycle
//   round_index  : index of the first round in the next beat
//   busy         : high whenever the engine is not idle
//   done         : one-cycle pulse, digest valid
//   digest       : result, packed like prev_hash
module hash_round_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned NUM_ROUNDS       = 64
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            feed_forward,
    input  logic [255:0]                    prev_hash,
    input  logic                            w_valid,
    input  logic [32*ROUNDS_PER_CYCLE-1:0]  w_data,
    input  logic [32*ROUNDS_PER_CYCLE-1:0]  k_data,
    output logic                            w_ready,
    output logic [$clog2(NUM_ROUNDS)-1:0]   round_index,
    output logic                            busy,
    output logic                            done,
    output logic [255:0]                    digest
);

    localparam int unsigned IDX_W = $clog2(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
    localparam logic [IDX_W-1:0] IDX_STEP  = IDX_W'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        FINAL
    } state_t;

    state_t state;
    state_t state_next;

    // Word 0 is a, word 7 is h, matching the prev_hash/digest packing.
    logic [7:0][31:0] hold;
    logic [7:0][31:0] work;
    logic [7:0][31:0] work_next;
    logic [7:0][31:0] sum;
    logic             mode;
    logic             take_start;
    logic             last_beat;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    assign take_start = start && !abort;
    assign last_beat  = (round_index == LAST_BEAT);
    assign w_ready    = (state == RUN);
    assign busy       = (state != IDLE);

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (take_start) state_next = LOAD;
            LOAD:    state_next = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                     state_next = IDLE;
                else if (w_valid && last_beat) state_next = FINAL;
            end
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // ROUNDS_PER_CYCLE chained rounds; each round shifts the working words
    // up by one position, inserts T1+T2 as the new a and adds T1 into e.
    always_comb begin
        logic [7:0][31:0] v;
        logic [31:0]      t1;
        logic [31:0]      t2;
        v  = work;
        t1 = '0;
        t2 = '0;
        for (int unsigned r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            t1 = v[7] + big_sigma1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
               + k_data[32*r +: 32] + w_data[32*r +: 32];
            t2 = big_sigma0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v    = {v[6:0], t1 + t2};
            v[4] = v[4] + t1;
        end
        work_next = v;
    end

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i] = work[i] + hold[i];
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold        <= '0;
            work        <= '0;
            mode        <= 1'b0;
            round_index <= '0;
            digest      <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_start) begin
                        hold <= prev_hash;
                        mode <= feed_forward;
                    end
                end
                LOAD: begin
                    round_index <= '0;
                    if (!abort) work <= hold;
                end
                RUN: begin
                    if (abort) begin
                        round_index <= '0;
                    end else if (w_valid) begin
                        work        <= work_next;
                        round_index <= last_beat ? '0 : round_index + IDX_STEP;
                    end
                end
                FINAL: begin
                    if (!abort) begin
                        digest <= mode ? sum : work;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
